// File: rtl/seven_seg_scan_if.sv
// Display-register side of the seven-segment scanner: digit codes and blink
// mask in, segment/anode pins and frame marker out.
interface seven_seg_scan_if #(
    parameter int DIGITS = 8
);
    logic                  enable;
    logic [5*DIGITS-1:0]   data;
    logic [DIGITS-1:0]     blink_mask;
    logic [7:0]            segments;
    logic [DIGITS-1:0]     anodes;
    logic                  frame_start;

    modport master (
        output enable, data, blink_mask,
        input  segments, anodes, frame_start
    );

    modport slave (
        input  enable, data, blink_mask,
        output segments, anodes, frame_start
    );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver with frame-coherent
// capture, per-digit blink, optional hex glyphs and anti-ghosting dead time.
module seven_seg_scan #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 2,
    parameter int BLINK_FRAMES = 64,
    parameter int HEX_EN       = 0
) (
    input  logic              clk,
    input  logic              rst,
    seven_seg_scan_if.slave   bus
);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [FC_W-1:0]      r_fcnt;
    logic                 r_phase;
    logic [5*DIGITS-1:0]  r_sh_data;
    logic [DIGITS-1:0]    r_sh_mask;
    logic [7:0]           r_seg;
    logic [DIGITS-1:0]    r_an;

    logic                 w_cnt_tc;
    logic                 w_idx_tc;
    logic                 w_frame;
    logic                 w_lit;
    logic                 w_blank;
    logic [4:0]           w_code;
    logic [6:0]           w_glyph;

    assign w_cnt_tc = (r_cnt == CNT_W'(SCAN_DIV - 1));
    assign w_idx_tc = (r_idx == IDX_W'(DIGITS - 1));
    assign w_frame  = (r_cnt == '0) && (r_idx == '0);
    assign w_code   = r_sh_data[5*int'(r_idx) +: 5];
    assign w_lit    = bus.enable && (int'(r_cnt) >= BLANK_CYCLES);
    assign w_blank  = r_phase && r_sh_mask[r_idx];

    // Masked with rst so the pulse stays low while reset is held, yet is
    // high in the very first cycle after release.
    assign bus.frame_start = w_frame && !rst;
    assign bus.segments    = r_seg;
    assign bus.anodes      = r_an;

    always_comb begin
        w_glyph = 7'b1111111;
        case (w_code[3:0])
            4'd0: w_glyph = 7'b0000001;
            4'd1: w_glyph = 7'b1001111;
            4'd2: w_glyph = 7'b0010010;
            4'd3: w_glyph = 7'b0000110;
            4'd4: w_glyph = 7'b1001100;
            4'd5: w_glyph = 7'b0100100;
            4'd6: w_glyph = 7'b0100000;
            4'd7: w_glyph = 7'b0001111;
            4'd8: w_glyph = 7'b0000000;
            4'd9: w_glyph = 7'b0001100;
            default: begin
                if (HEX_EN != 0) begin
                    case (w_code[3:0])
                        4'd10:   w_glyph = 7'b0001000;
                        4'd11:   w_glyph = 7'b1100000;
                        4'd12:   w_glyph = 7'b0110001;
                        4'd13:   w_glyph = 7'b1000010;
                        4'd14:   w_glyph = 7'b0110000;
                        default: w_glyph = 7'b0111000;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_fcnt    <= '0;
            r_phase   <= 1'b0;
            r_sh_data <= '0;
            r_sh_mask <= '0;
            r_seg     <= '1;
            r_an      <= '1;
        end else begin
            if (w_cnt_tc) begin
                r_cnt <= '0;
                r_idx <= w_idx_tc ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_frame) begin
                r_sh_data <= bus.data;
                r_sh_mask <= bus.blink_mask;
            end

            // Frames are counted as they end, so frame 0 after reset is the
            // first of BLINK_FRAMES lit frames.
            if (w_cnt_tc && w_idx_tc) begin
                if (r_fcnt == FC_W'(BLINK_FRAMES - 1)) begin
                    r_fcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_fcnt <= r_fcnt + FC_W'(1);
                end
            end

            r_an  <= w_lit ? ~(DIGITS'(1) << r_idx) : '1;
            r_seg <= (!w_lit || w_blank) ? 8'hFF : {w_glyph, ~w_code[4]};
        end
    end
endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: a cycle-indexed reference model pushes
// the expected pins for each upcoming cycle; each test pops and compares.
module tb_seven_seg_scan;
    localparam int D  = 4;
    localparam int SD = 4;
    localparam int BC = 1;
    localparam int BF = 2;
    localparam int FRAME = SD * D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        t_en;
    logic [19:0] t_data;
    logic [3:0]  t_mask;

    always #5 clk = ~clk;

    seven_seg_scan_if #(.DIGITS(D)) bus0 ();
    seven_seg_scan_if #(.DIGITS(D)) bus1 ();

    assign bus0.enable     = t_en;
    assign bus0.data       = t_data;
    assign bus0.blink_mask = t_mask;
    assign bus1.enable     = t_en;
    assign bus1.data       = t_data;
    assign bus1.blink_mask = t_mask;

    seven_seg_scan #(.DIGITS(D), .SCAN_DIV(SD), .BLANK_CYCLES(BC),
                     .BLINK_FRAMES(BF), .HEX_EN(0))
        u_dut (.clk(clk), .rst(rst), .bus(bus0));

    seven_seg_scan #(.DIGITS(D), .SCAN_DIV(SD), .BLANK_CYCLES(BC),
                     .BLINK_FRAMES(BF), .HEX_EN(1))
        u_hex (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic [7:0] seg_hex;
        logic       fs;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [20:0] w_obs;
    int unsigned k;
    logic [19:0] m_data;
    logic [3:0]  m_mask;
    int          n_pass = 0;
    int          n_total = 0;

    assign w_obs = {bus0.anodes, bus0.segments, bus1.segments, bus0.frame_start};

    function automatic logic [6:0] glyph(input logic [3:0] v, input bit hex);
        case (v)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0001100;
            4'd10: return hex ? 7'b0001000 : 7'b1111111;
            4'd11: return hex ? 7'b1100000 : 7'b1111111;
            4'd12: return hex ? 7'b0110001 : 7'b1111111;
            4'd13: return hex ? 7'b1000010 : 7'b1111111;
            4'd14: return hex ? 7'b0110000 : 7'b1111111;
            default: return hex ? 7'b0111000 : 7'b1111111;
        endcase
    endfunction

    // Pushes the pins expected one cycle later, then moves to the next sample point.
    task automatic advance();
        int unsigned cnt, idx, phase;
        bit          lit, blank;
        logic [4:0]  code;
        exp_t        x;
        cnt   = k % SD;
        idx   = (k / SD) % D;
        phase = (k / (FRAME * BF)) % 2;
        lit   = t_en && (cnt >= BC);
        blank = (phase == 1) && m_mask[idx];
        code  = m_data[5*idx +: 5];
        x.an      = lit ? ~(4'b0001 << idx) : 4'hF;
        x.seg     = (!lit || blank) ? 8'hFF : {glyph(code[3:0], 1'b0), ~code[4]};
        x.seg_hex = (!lit || blank) ? 8'hFF : {glyph(code[3:0], 1'b1), ~code[4]};
        x.fs      = ((k + 1) % FRAME) == 0;
        sb.push_back(x);
        if (k % FRAME == 0) begin
            m_data = t_data;
            m_mask = t_mask;
        end
        @(posedge clk);
        @(negedge clk);
        k++;
    endtask

    task automatic test_reset();
        t_en   = 1'b1;
        t_data = {5'h03, 5'h02, 5'h01, 5'h00};
        t_mask = 4'b0000;
        rst    = 1'b1;
        @(negedge clk);
        n_total++;
        if (w_obs !== {4'hF, 8'hFF, 8'hFF, 1'b0})
            $display("FAIL reset_held got %b want %b", w_obs, {4'hF, 8'hFF, 8'hFF, 1'b0});
        else n_pass++;
        rst = 1'b0;
        #1;
        k = 0; m_data = '0; m_mask = '0; sb.delete();
        n_total++;
        if (w_obs !== {4'hF, 8'hFF, 8'hFF, 1'b1})
            $display("FAIL reset_release got %b want %b", w_obs, {4'hF, 8'hFF, 8'hFF, 1'b1});
        else n_pass++;
        for (int i = 0; i < 2 * FRAME; i++) begin
            advance();
            e = sb.pop_front();
            n_total++;
            if (w_obs !== e) $display("FAIL scan_order k=%0d got %b want %b", k, w_obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_frame_coherence();
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (i == 1) t_data[4:0] = 5'h18;
            if (i == FRAME) t_data[9:5] = 5'h15;
            advance();
            e = sb.pop_front();
            n_total++;
            if (w_obs !== e) $display("FAIL frame_coherence k=%0d got %b want %b", k, w_obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_hex_codes();
        t_data[14:10] = 5'h0A;
        for (int i = 0; i < 2 * FRAME; i++) begin
            advance();
            e = sb.pop_front();
            n_total++;
            if (w_obs !== e) $display("FAIL hex_0A k=%0d got %b want %b", k, w_obs, e);
            else n_pass++;
        end
        t_data[14:10] = 5'h1F;
        for (int i = 0; i < 2 * FRAME; i++) begin
            advance();
            e = sb.pop_front();
            n_total++;
            if (w_obs !== e) $display("FAIL hex_1F k=%0d got %b want %b", k, w_obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_enable();
        while (k % SD != 2) begin
            advance();
            e = sb.pop_front();
            n_total++;
            if (w_obs !== e) $display("FAIL enable_pre k=%0d got %b want %b", k, w_obs, e);
            else n_pass++;
        end
        for (int i = 0; i < 10 + 2 * FRAME; i++) begin
            t_en = (i >= 10);
            advance();
            e = sb.pop_front();
            n_total++;
            if (w_obs !== e) $display("FAIL enable k=%0d got %b want %b", k, w_obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        t_data = {5'h07, 5'h06, 5'h05, 5'h04};
        while (k % FRAME != 10) begin
            advance();
            e = sb.pop_front();
            n_total++;
            if (w_obs !== e) $display("FAIL async_pre k=%0d got %b want %b", k, w_obs, e);
            else n_pass++;
        end
        n_total++;
        if (bus0.anodes !== 4'b1011) $display("FAIL async_digit2_lit got %b want %b", bus0.anodes, 4'b1011);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (w_obs !== {4'hF, 8'hFF, 8'hFF, 1'b0})
            $display("FAIL async_dark got %b want %b", w_obs, {4'hF, 8'hFF, 8'hFF, 1'b0});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        k = 0; m_data = '0; m_mask = '0; sb.delete();
        n_total++;
        if (w_obs !== {4'hF, 8'hFF, 8'hFF, 1'b1})
            $display("FAIL async_release got %b want %b", w_obs, {4'hF, 8'hFF, 8'hFF, 1'b1});
        else n_pass++;
        for (int i = 0; i < 2 * FRAME; i++) begin
            advance();
            e = sb.pop_front();
            n_total++;
            if (w_obs !== e) $display("FAIL async_after k=%0d got %b want %b", k, w_obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_blink();
        int unsigned dark_slots;
        t_mask = 4'b0010;
        t_data = {5'h03, 5'h02, 5'h01, 5'h00};
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        k = 0; m_data = '0; m_mask = '0; sb.delete();
        dark_slots = 0;
        for (int i = 0; i < 6 * FRAME; i++) begin
            advance();
            e = sb.pop_front();
            if (bus0.anodes == 4'b1101 && bus0.segments == 8'hFF) dark_slots++;
            n_total++;
            if (w_obs !== e) $display("FAIL blink k=%0d got %b want %b", k, w_obs, e);
            else n_pass++;
        end
        // Frames 2-3 blank digit 1 for three lit cycles each.
        n_total++;
        if (dark_slots != 6) $display("FAIL blink_dark_count got %0d want %0d", dark_slots, 6);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_frame_coherence();
        test_hex_codes();
        test_enable();
        test_async_reset();
        test_blink();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
